// File: rtl/pad_output_bank_pkg.sv
// Shared types and elaboration helpers for the staggered output pad bank.
// The bank FSM walks IDLE -> RAMP_UP -> ACTIVE -> RAMP_DOWN -> IDLE.
package pad_output_bank_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    ACTIVE    = 2'd2,
    RAMP_DOWN = 2'd3
  } bank_state_e;

  // A zero-width attribute bus is still given one bit so the port stays legal.
  function automatic int padattr_rnd(input int padattr);
    return (padattr == 0) ? 1 : padattr;
  endfunction

  function automatic int cnt_width(input int stagger_cycles);
    return (stagger_cycles > 1) ? $clog2(stagger_cycles) : 1;
  endfunction

endpackage

// File: rtl/pad_output_bank_channel.sv
// One output-only pad cell: optional 1-cycle data/oe register, bypass mux and
// the tristate driver gated by the bank release bit.
module pad_output_bank_channel (
  input  logic clk_i,
  input  logic rst_i,
  input  logic rel_i,
  input  logic reg_mode_i,
  input  logic pad_in_i,
  input  logic pad_oe_i,
  inout  wire  pad_io
);

  logic data_q, data_d;
  logic oe_q, oe_d;
  logic data_eff;
  logic oe_eff;

  // The registers track the inputs every cycle, whatever the bank state, so
  // switching a pad into registered mode never exposes stale data.
  always_comb begin
    data_d = pad_in_i;
    oe_d   = pad_oe_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q <= 1'b0;
      oe_q   <= 1'b0;
    end else begin
      data_q <= data_d;
      oe_q   <= oe_d;
    end
  end

  always_comb begin
    data_eff = reg_mode_i ? data_q : pad_in_i;
    oe_eff   = reg_mode_i ? oe_q   : pad_oe_i;
  end

  assign pad_io = (rel_i && oe_eff) ? data_eff : 1'bz;

endmodule

// File: rtl/pad_output_bank.sv
// Bank of output-only pads whose output enables are released one pad at a time
// (lowest first) and withdrawn highest first, STAGGER_CYCLES apart.
module pad_output_bank
  import pad_output_bank_pkg::*;
#(
  parameter  int NUM_PADS       = 8,
  parameter  int STAGGER_CYCLES = 4,
  parameter  int PADATTR        = 16,
  localparam int PADATTR_RND    = padattr_rnd(PADATTR)
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            bank_en_i,
  input  logic                            force_off_i,
  input  logic [NUM_PADS-1:0]             reg_mode_i,
  input  logic [NUM_PADS-1:0]             pad_in_i,
  input  logic [NUM_PADS-1:0]             pad_oe_i,
  output logic [NUM_PADS-1:0]             pad_out_o,
  inout  wire  [NUM_PADS-1:0]             pad_io,
  input  logic [NUM_PADS*PADATTR_RND-1:0] pad_attributes_i,
  output logic                            ready_o,
  output logic                            busy_o
);

  localparam int NREL_W = $clog2(NUM_PADS + 1);
  localparam int CNT_W  = cnt_width(STAGGER_CYCLES);

  localparam logic [NREL_W-1:0] ONE_REL  = NREL_W'(1);
  localparam logic [NREL_W-1:0] LAST_REL = NREL_W'(NUM_PADS - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(STAGGER_CYCLES - 1);

  bank_state_e         state_q, state_d;
  logic [NREL_W-1:0]   n_rel_q, n_rel_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [NUM_PADS-1:0] rel_q, rel_d;
  logic                ready_q, ready_d;
  logic                busy_q, busy_d;

  // Attributes are carried for interface compatibility with real pad cells.
  logic unused_attr;
  assign unused_attr = ^pad_attributes_i;

  always_comb begin
    state_d = state_q;
    n_rel_d = n_rel_q;
    cnt_d   = cnt_q;

    if (force_off_i) begin
      state_d = IDLE;
      n_rel_d = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bank_en_i) begin
            n_rel_d = ONE_REL;
            cnt_d   = '0;
            state_d = (NUM_PADS == 1) ? ACTIVE : RAMP_UP;
          end
        end

        RAMP_UP: begin
          if (!bank_en_i) begin
            // Reversal: withdraw the most recently released pad right away.
            n_rel_d = n_rel_q - ONE_REL;
            cnt_d   = '0;
            state_d = (n_rel_q == ONE_REL) ? IDLE : RAMP_DOWN;
          end else if (cnt_q == CNT_LAST) begin
            n_rel_d = n_rel_q + ONE_REL;
            cnt_d   = '0;
            if (n_rel_q == LAST_REL) begin
              state_d = ACTIVE;
            end
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end

        ACTIVE: begin
          if (!bank_en_i) begin
            n_rel_d = n_rel_q - ONE_REL;
            cnt_d   = '0;
            state_d = (n_rel_q == ONE_REL) ? IDLE : RAMP_DOWN;
          end
        end

        RAMP_DOWN: begin
          if (bank_en_i) begin
            n_rel_d = n_rel_q + ONE_REL;
            cnt_d   = '0;
            state_d = (n_rel_q == LAST_REL) ? ACTIVE : RAMP_UP;
          end else if (cnt_q == CNT_LAST) begin
            n_rel_d = n_rel_q - ONE_REL;
            cnt_d   = '0;
            if (n_rel_q == ONE_REL) begin
              state_d = IDLE;
            end
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end

        default: begin
          state_d = IDLE;
          n_rel_d = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Release mask and status flags are decoded from the next state so they
  // change on the same edge as the counters.
  always_comb begin
    rel_d = '0;
    for (int i = 0; i < NUM_PADS; i++) begin
      rel_d[i] = (NREL_W'(i) < n_rel_d);
    end
    ready_d = (state_d == ACTIVE);
    busy_d  = (state_d == RAMP_UP) || (state_d == RAMP_DOWN);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      n_rel_q <= '0;
      cnt_q   <= '0;
      rel_q   <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      n_rel_q <= n_rel_d;
      cnt_q   <= cnt_d;
      rel_q   <= rel_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  assign ready_o   = ready_q;
  assign busy_o    = busy_q;
  assign pad_out_o = '0;

  for (genvar g = 0; g < NUM_PADS; g++) begin : g_pad
    pad_output_bank_channel u_channel (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .rel_i      (rel_q[g]),
      .reg_mode_i (reg_mode_i[g]),
      .pad_in_i   (pad_in_i[g]),
      .pad_oe_i   (pad_oe_i[g]),
      .pad_io     (pad_io[g])
    );
  end

endmodule

// File: tb/tb_pad_output_bank.sv
// Directed bench for pad_output_bank with 4 pads and a 3-cycle stagger.
// Pad nets carry pull-ups, so a high-impedance pad reads back as 1.
module tb_pad_output_bank;

  localparam int NP = 4;
  localparam int SC = 3;
  localparam int PA = 16;

  logic            clk;
  logic            rst;
  logic            bank_en;
  logic            force_off;
  logic [NP-1:0]   reg_mode;
  logic [NP-1:0]   pad_in;
  logic [NP-1:0]   pad_oe;
  logic [NP-1:0]   pad_out;
  wire  [NP-1:0]   pad_w;
  logic [NP*PA-1:0] attrs;
  logic            ready;
  logic            busy;

  int n_compared;
  int n_mismatched;

  for (genvar g = 0; g < NP; g++) begin : g_pull
    pullup (pad_w[g]);
  end

  pad_output_bank #(
    .NUM_PADS       (NP),
    .STAGGER_CYCLES (SC),
    .PADATTR        (PA)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .bank_en_i        (bank_en),
    .force_off_i      (force_off),
    .reg_mode_i       (reg_mode),
    .pad_in_i         (pad_in),
    .pad_oe_i         (pad_oe),
    .pad_out_o        (pad_out),
    .pad_io           (pad_w),
    .pad_attributes_i (attrs),
    .ready_o          (ready),
    .busy_o           (busy)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver: advance one edge and settle before sampling
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Pads released below n, data 0 and oe all on: released pads read 0, others 1.
  function automatic logic [NP-1:0] pads_released(input int n);
    logic [NP-1:0] m;
    m = '0;
    for (int i = 0; i < NP; i++) if (i < n) m[i] = 1'b1;
    return ~m;
  endfunction

  task automatic check_bank(input string tag, input int n, input logic exp_busy, input logic exp_ready);
    check_val({tag, " pads"}, 32'(pad_w), 32'(pads_released(n)));
    check_val({tag, " busy"}, 32'(busy), 32'(exp_busy));
    check_val({tag, " ready"}, 32'(ready), 32'(exp_ready));
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    attrs     = {$urandom(), $urandom()};
    rst       = 1'b1;
    bank_en   = 1'b1;
    force_off = 1'b0;
    reg_mode  = '0;
    pad_in    = '0;
    pad_oe    = 4'hF;

    // Reset: enable requested but everything must stay off
    cyc();
    cyc();
    check_bank("reset", 0, 1'b0, 1'b0);
    check_val("reset pad_out", 32'(pad_out), 32'h0);

    rst     = 1'b0;
    bank_en = 1'b0;
    cyc();
    check_bank("idle", 0, 1'b0, 1'b0);

    // Ramp up: bank_en first sampled at edge 0, pad i released after edge 3*i
    bank_en = 1'b1;
    for (int k = 0; k <= 9; k++) begin
      cyc();
      check_bank($sformatf("up e%0d", k), (1 + k / SC > NP) ? NP : 1 + k / SC, k < 9, k >= 9);
    end

    // Data path in bypass mode
    pad_in = 4'b1010;
    #1;
    check_val("active data 1010", 32'(pad_w), 32'h A);
    pad_in = 4'b0101;
    #1;
    check_val("active data 0101", 32'(pad_w), 32'h5);
    pad_in = 4'b0000;
    pad_oe = 4'b0011;
    #1;
    check_val("active oe 0011", 32'(pad_w), 32'hC);
    pad_oe = 4'hF;
    cyc();
    check_bank("active hold", NP, 1'b0, 1'b1);

    // Ramp down: highest pad withdrawn first
    bank_en = 1'b0;
    for (int k = 0; k <= 9; k++) begin
      cyc();
      check_bank($sformatf("down e%0d", k), (3 - k / SC < 0) ? 0 : 3 - k / SC, k < 9, 1'b0);
    end
    check_val("down pad_out", 32'(pad_out), 32'h0);

    // Reversal during ramp up, left to fall back to idle
    bank_en = 1'b1;
    for (int k = 0; k <= 3; k++) cyc();
    check_bank("revA e3", 2, 1'b1, 1'b0);
    bank_en = 1'b0;
    cyc();
    check_bank("revA e4", 1, 1'b1, 1'b0);
    cyc();
    cyc();
    check_bank("revA e6", 1, 1'b1, 1'b0);
    cyc();
    check_bank("revA e7", 0, 1'b0, 1'b0);

    // Reversal down then re-raise
    bank_en = 1'b1;
    for (int k = 0; k <= 3; k++) cyc();
    bank_en = 1'b0;
    cyc();
    check_bank("revB e4", 1, 1'b1, 1'b0);
    bank_en = 1'b1;
    cyc();
    check_bank("revB e5", 2, 1'b1, 1'b0);
    cyc();
    cyc();
    check_bank("revB e7", 2, 1'b1, 1'b0);
    cyc();
    check_bank("revB e8", 3, 1'b1, 1'b0);
    cyc();
    cyc();
    cyc();
    check_bank("revB e11", 4, 1'b0, 1'b1);

    // Emergency disable with bank_en held high
    force_off = 1'b1;
    cyc();
    check_bank("force e30", 0, 1'b0, 1'b0);
    for (int k = 31; k <= 34; k++) cyc();
    check_bank("force e34", 0, 1'b0, 1'b0);
    force_off = 1'b0;
    cyc();
    check_bank("force e35", 1, 1'b1, 1'b0);
    for (int k = 36; k <= 44; k++) cyc();
    check_bank("force e44", NP, 1'b0, 1'b1);

    // Registered mode on pad 0 only
    reg_mode = 4'b0001;
    pad_in   = 4'b0011;
    cyc();
    check_val("reg settle", 32'(pad_w), 32'h3);
    pad_in = 4'b0000;
    #1;
    check_val("reg before edge", 32'(pad_w), 32'h1);
    cyc();
    check_val("reg after edge", 32'(pad_w), 32'h0);
    pad_oe = 4'b1110;
    #1;
    check_val("reg oe before edge", 32'(pad_w), 32'h0);
    cyc();
    check_val("reg oe after edge", 32'(pad_w), 32'h1);
    pad_oe   = 4'hF;
    reg_mode = '0;

    // Reset in the middle of a ramp
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    bank_en = 1'b1;
    for (int k = 0; k <= 3; k++) cyc();
    check_bank("midramp e3", 2, 1'b1, 1'b0);
    rst = 1'b1;
    cyc();
    check_bank("midramp reset", 0, 1'b0, 1'b0);
    rst     = 1'b0;
    bank_en = 1'b0;
    cyc();
    cyc();
    check_bank("midramp after", 0, 1'b0, 1'b0);
    check_val("final pad_out", 32'(pad_out), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
